mc_ctrl: RTL

Multi-cycle main controller for the single-issue MIPS-subset CPU. It sequences the fetch datapath (PC register, instruction ROM, IR) and the downstream register file, ALU and data RAM through IF/ID/EXE/MEM/WB states. The controller updates on posedge clk. The datapath registers (PC, IR, regfile, RAM) capture on negedge, so every control output is stable for half a cycle before use. It also provides run/step gating and a retired-instruction counter for the board debug display.

---
 rtl/mc_pkg.sv | 58 +++++
 rtl/mc_decode.sv | 44 ++++
 rtl/mc_ctrl.sv | 139 +++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, opcodes,
// funct codes, ALU operation codes, PC source selects and decode classes.
package mc_pkg;

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        CL_R     = 3'd0,
        CL_IMM_S = 3'd1,
        CL_IMM_Z = 3'd2,
        CL_LW    = 3'd3,
        CL_SW    = 3'd4,
        CL_BR    = 3'd5,
        CL_J     = 3'd6,
        CL_ILL   = 3'd7
    } iclass_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_NOR = 3'b011;
    localparam logic [2:0] ALU_ADD = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;
    localparam logic [2:0] ALU_SLL = 3'b111;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder: (op, funct) -> instruction class and ALU op.
module mc_decode
    import mc_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] funct,
    output logic [2:0] cls,
    output logic [2:0] alu_op
);

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        cls    = CL_ILL;
        alu_op = ALU_ADD;
        case (op)
            OP_RTYPE: begin
                cls = CL_R;
                case (funct)
                    F_ADD:   alu_op = ALU_ADD;
                    F_SUB:   alu_op = ALU_SUB;
                    F_AND:   alu_op = ALU_AND;
                    F_OR:    alu_op = ALU_OR;
                    F_XOR:   alu_op = ALU_XOR;
                    F_NOR:   alu_op = ALU_NOR;
                    F_SLT:   alu_op = ALU_SLT;
                    F_SLLV:  alu_op = ALU_SLL;
                    default: cls    = CL_ILL;
                endcase
            end
            OP_ADDI: begin cls = CL_IMM_S; alu_op = ALU_ADD; end
            OP_SLTI: begin cls = CL_IMM_S; alu_op = ALU_SLT; end
            OP_ANDI: begin cls = CL_IMM_Z; alu_op = ALU_AND; end
            OP_ORI:  begin cls = CL_IMM_Z; alu_op = ALU_OR;  end
            OP_XORI: begin cls = CL_IMM_Z; alu_op = ALU_XOR; end
            OP_LW:   begin cls = CL_LW;    alu_op = ALU_ADD; end
            OP_SW:   begin cls = CL_SW;    alu_op = ALU_ADD; end
            OP_BEQ:  begin cls = CL_BR;    alu_op = ALU_SUB; end
            OP_BNE:  begin cls = CL_BR;    alu_op = ALU_SUB; end
            OP_J:    cls = CL_J;
            default: cls = CL_ILL;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller: IF/ID/EXE/MEM/WB sequencing, run/step gating
// and retired-instruction counter. Outputs are set up for negedge capture.
module mc_ctrl
    import mc_pkg::*;
#(
    parameter int         CNT_W     = 32,
    parameter logic [2:0] RST_STATE = 3'd0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic [5:0]       op,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ir_write,
    output logic             reg_write,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             mem_write,
    output logic             alu_src_b,
    output logic             ext_sign,
    output logic [2:0]       alu_op,
    output logic [2:0]       state,
    output logic             illegal,
    output logic [CNT_W-1:0] inst_cnt
);

    state_t           state_q, state_d;
    logic [5:0]       op_q, funct_q;
    logic [CNT_W-1:0] cnt_q;
    logic             retire;
    logic [5:0]       dec_op, dec_funct;
    logic [2:0]       cls, dec_alu;

    // ID decodes the live IR fields; later states use the copy latched in ID.
    assign dec_op    = (state_q == S_ID) ? op    : op_q;
    assign dec_funct = (state_q == S_ID) ? funct : funct_q;

    mc_decode u_decode (
        .op     (dec_op),
        .funct  (dec_funct),
        .cls    (cls),
        .alu_op (dec_alu)
    );

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (rst) begin
            state_q <= state_t'(RST_STATE);
            op_q    <= '0;
            funct_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_ID) begin
                op_q    <= op;
                funct_q <= funct;
            end
            if (retire)
                cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        state_d    = S_IF;
        pc_write   = 1'b0;
        pc_src     = PC_PLUS4;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        mem_write  = 1'b0;
        alu_src_b  = 1'b0;
        ext_sign   = 1'b0;
        alu_op     = ALU_ADD;
        illegal    = 1'b0;
        retire     = 1'b0;
        // Everything stays at its default while reset is held.
        if (!rst) begin
            case (state_q)
                S_IF: begin
                    if (run) begin
                        pc_write = 1'b1;
                        ir_write = 1'b1;
                        state_d  = S_ID;
                    end
                end
                S_ID: begin
                    case (cls)
                        CL_J: begin
                            pc_write = 1'b1;
                            pc_src   = PC_JUMP;
                            retire   = 1'b1;
                        end
                        CL_ILL:  illegal = 1'b1;
                        default: state_d = S_EXE;
                    endcase
                end
                S_EXE: begin
                    alu_op = dec_alu;
                    case (cls)
                        CL_R:     state_d = S_WB;
                        CL_IMM_S: begin ext_sign = 1'b1; alu_src_b = 1'b1; state_d = S_WB;  end
                        CL_IMM_Z: begin alu_src_b = 1'b1; state_d = S_WB; end
                        CL_LW,
                        CL_SW:    begin ext_sign = 1'b1; alu_src_b = 1'b1; state_d = S_MEM; end
                        CL_BR: begin
                            pc_src   = PC_BRANCH;
                            pc_write = zero ^ (op_q == OP_BNE);
                            retire   = 1'b1;
                        end
                        default: state_d = S_IF;
                    endcase
                end
                S_MEM: begin
                    if (cls == CL_LW) begin
                        state_d = S_WB;
                    end else if (cls == CL_SW) begin
                        mem_write = 1'b1;
                        retire    = 1'b1;
                    end
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = (cls == CL_R);
                    mem_to_reg = (cls == CL_LW);
                    retire     = 1'b1;
                end
                default: state_d = S_IF;
            endcase
        end
    end

    assign state    = state_q;
    assign inst_cnt = cnt_q;

endmodule
